alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 169 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//
// Shares one external combinational ALU between NUM_REQ requesters. A
// round-robin arbiter picks one pending request in IDLE and registers its
// operands and op code onto the alu_* outputs. In EXEC the ALU result is
// captured. In RESP the result is returned with the requester index.
//
// Handshake semantics (both channels): a transfer happens on a rising clk_i
// edge where valid and ready are both high. A source holds valid and its
// payload stable until the transfer. Request sources may withdraw valid
// before acceptance, in which case the request never happened. Ready never
// depends on the same channel's payload, and rsp_ready_i has no
// combinational path to any output.
//
// Ports:
//   clk_i, rst_ni              clock (rising edge), async active-low reset
//   req_valid_i[NUM_REQ]       per-requester request valid
//   req_ready_o[NUM_REQ]       per-requester accept, one-hot or zero
//   req_data1_i / req_data2_i  packed operands, requester k at [k*DATA_W +: DATA_W]
//   req_op_i                   packed op codes, requester k at [k*OP_W +: OP_W]
//   alu_data1_o / alu_data2_o  registered ALU operands
//   alu_op_o                   registered ALU op code
//   alu_result_i               ALU combinational result
//   rsp_valid_o / rsp_ready_i  response handshake
//   rsp_id_o                   index of the requester being answered
//   rsp_result_o               registered result
//   busy_o                     high in EXEC or RESP
//   ops_done_o                 completed-operation counter, wraps at 16 bits
//
// FSM state is fully observable: busy_o = (EXEC or RESP), rsp_valid_o = RESP.

module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0] req_data1_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data2_i,
  input  logic [NUM_REQ*OP_W-1:0]   req_op_i,
  output logic [DATA_W-1:0]         alu_data1_o,
  output logic [DATA_W-1:0]         alu_data2_o,
  output logic [OP_W-1:0]           alu_op_o,
  input  logic [DATA_W-1:0]         alu_result_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [ID_W-1:0]           rsp_id_o,
  output logic [DATA_W-1:0]         rsp_result_o,
  output logic                      busy_o,
  output logic [15:0]               ops_done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  logic [DATA_W-1:0]   alu_data1_q, alu_data1_d;
  logic [DATA_W-1:0]   alu_data2_q, alu_data2_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic [15:0]         ops_done_q, ops_done_d;

  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     cand;
  logic [NUM_REQ-1:0]  req_ready;

  // Round-robin search: start one past the last winner and wrap, so a
  // requester that was just served is considered last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(last_grant_q) + i) % NUM_REQ);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    alu_data1_d  = alu_data1_q;
    alu_data2_d  = alu_data2_q;
    alu_op_d     = alu_op_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    ops_done_d   = ops_done_q;
    req_ready    = '0;

    case (state_q)
      S_IDLE: begin
        // The winner is by construction valid, so asserting its ready bit
        // completes the request handshake on this edge.
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          last_grant_d         = grant_idx;
          rsp_id_d             = grant_idx;
          alu_data1_d          = req_data1_i[grant_idx*DATA_W +: DATA_W];
          alu_data2_d          = req_data2_i[grant_idx*DATA_W +: DATA_W];
          alu_op_d             = req_op_i[grant_idx*OP_W +: OP_W];
          state_d              = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_result_d = alu_result_i;
        state_d      = S_RESP;
      end
      S_RESP: begin
        // Always return to IDLE: no request is accepted in the same cycle
        // as a response handshake.
        if (rsp_ready_i) begin
          ops_done_d = ops_done_q + 16'd1;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      alu_data1_q  <= '0;
      alu_data2_q  <= '0;
      alu_op_q     <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      alu_data1_q  <= alu_data1_d;
      alu_data2_q  <= alu_data2_d;
      alu_op_q     <= alu_op_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      ops_done_q   <= ops_done_d;
    end
  end

  // The grant is combinational from req_valid_i, so it is gated by reset
  // to keep every output at zero while rst_ni is low.
  assign req_ready_o  = rst_ni ? req_ready : '0;
  assign alu_data1_o  = alu_data1_q;
  assign alu_data2_o  = alu_data2_q;
  assign alu_op_o     = alu_op_q;
  assign rsp_valid_o  = (state_q == S_RESP);
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign busy_o       = (state_q != S_IDLE);
  assign ops_done_o   = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int OW = 2;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] d1, d2;
  logic [N*OW-1:0] op;
  logic [DW-1:0]   alu_d1, alu_d2, alu_res;
  logic [OW-1:0]   alu_op;
  logic            rsp_valid, rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_result;
  logic            busy;
  logic [15:0]     ops_done;

  alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW), .ID_W(IW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_data1_i(d1), .req_data2_i(d2), .req_op_i(op),
    .alu_data1_o(alu_d1), .alu_data2_o(alu_d2), .alu_op_o(alu_op),
    .alu_result_i(alu_res),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_result_o(rsp_result),
    .busy_o(busy), .ops_done_o(ops_done)
  );

  // ---------------- external ALU model ----------------
  logic          alu_ovr;
  logic [DW-1:0] alu_ovr_val;

  function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [OW-1:0] o);
    case (o)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_res = alu_ovr ? alu_ovr_val : alu_fn(alu_d1, alu_d2, alu_op);

  // ---------------- scoreboard / reference model ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];
  logic [15:0]   ops_exp;
  // Priority list: front is highest priority. A winner is rotated to the back.
  int prio_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    prio_q = {0, 1, 2, 3};
    exp_q.delete();
    ops_exp = 16'd0;
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    foreach (prio_q[i]) if (v[prio_q[i]]) return prio_q[i];
    return -1;
  endfunction

  task automatic model_commit(input int g);
    while (prio_q[N-1] != g) prio_q.push_back(prio_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic randomize_data();
    for (int k = 0; k < N; k++) begin
      d1[k*DW +: DW] = $urandom();
      d2[k*DW +: DW] = $urandom();
      op[k*OW +: OW] = OW'($urandom_range(0, 3));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk($sformatf("%s req_ready", tag), 64'(req_ready), 0);
    chk($sformatf("%s rsp_valid", tag), 64'(rsp_valid), 0);
    chk($sformatf("%s rsp_id", tag), 64'(rsp_id), 0);
    chk($sformatf("%s rsp_result", tag), 64'(rsp_result), 0);
    chk($sformatf("%s alu_d1", tag), 64'(alu_d1), 0);
    chk($sformatf("%s alu_d2", tag), 64'(alu_d2), 0);
    chk($sformatf("%s alu_op", tag), 64'(alu_op), 0);
    chk($sformatf("%s busy", tag), 64'(busy), 0);
    chk($sformatf("%s ops_done", tag), 64'(ops_done), 0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '1;  // ready must still read 0 while in reset
    rsp_ready = 1'b1;
    alu_ovr   = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    req_valid = '0;
    rst_n     = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // Called just after a negedge with the DUT in IDLE. Runs one full
  // operation; hold = number of cycles rsp_ready stays low in RESP.
  task automatic run_txn(input logic [N-1:0] mask, input int exp_id, input int hold,
                         input string tag);
    logic [DW-1:0] a, b, r;
    logic [OW-1:0] o;
    req_valid = mask;
    #1;
    chk($sformatf("%s grant", tag), 64'(req_ready), 64'(1) << exp_id);
    a = d1[exp_id*DW +: DW];
    b = d2[exp_id*DW +: DW];
    o = op[exp_id*OW +: OW];
    exp_q.push_back(alu_ovr ? alu_ovr_val : alu_fn(a, b, o));
    rsp_ready = (hold == 0);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk($sformatf("%s exec d1", tag), 64'(alu_d1), 64'(a));
    chk($sformatf("%s exec d2", tag), 64'(alu_d2), 64'(b));
    chk($sformatf("%s exec op", tag), 64'(alu_op), 64'(o));
    chk($sformatf("%s exec busy", tag), 64'(busy), 1);
    chk($sformatf("%s exec ready", tag), 64'(req_ready), 0);
    chk($sformatf("%s exec rsp_valid", tag), 64'(rsp_valid), 0);
    @(negedge clk);
    r = exp_q.pop_front();
    chk($sformatf("%s rsp_valid", tag), 64'(rsp_valid), 1);
    chk($sformatf("%s rsp_id", tag), 64'(rsp_id), 64'(exp_id));
    chk($sformatf("%s rsp_result", tag), 64'(rsp_result), 64'(r));
    if (hold > 0) begin
      req_valid = mask;  // requests pending during back-pressure must wait
      for (int k = 0; k < hold; k++) begin
        #1;
        chk($sformatf("%s bp valid", tag), 64'(rsp_valid), 1);
        chk($sformatf("%s bp id", tag), 64'(rsp_id), 64'(exp_id));
        chk($sformatf("%s bp result", tag), 64'(rsp_result), 64'(r));
        chk($sformatf("%s bp ready", tag), 64'(req_ready), 0);
        chk($sformatf("%s bp busy", tag), 64'(busy), 1);
        if (k == hold - 1) begin
          rsp_ready = 1'b1;
          req_valid = '0;
        end
        @(negedge clk);
      end
    end else begin
      @(negedge clk);
    end
    ops_exp = ops_exp + 16'd1;
    chk($sformatf("%s idle rsp_valid", tag), 64'(rsp_valid), 0);
    chk($sformatf("%s idle busy", tag), 64'(busy), 0);
    chk($sformatf("%s ops_done", tag), 64'(ops_done), 64'(ops_exp));
    rsp_ready = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] mask;
    int           exp_id;
    int           hold;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // Watchdog: any hang ends the run with a FAIL line.
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int grants, last_cyc, cyc, g;
    logic [IW-1:0] id_q[$];
    logic [N-1:0] m;

    req_valid = '0;
    rsp_ready = 1'b1;
    alu_ovr   = 1'b0;
    alu_ovr_val = '0;
    d1 = '0; d2 = '0; op = '0;
    do_reset();

    // Single request from requester 2, ALU result forced to DEADBEEF.
    d1[2*DW +: DW] = 32'd5;
    d2[2*DW +: DW] = 32'd7;
    op[2*OW +: OW] = 2'b01;
    alu_ovr = 1'b1;
    alu_ovr_val = 32'hDEADBEEF;
    run_txn(4'b0100, 2, 0, "single");
    alu_ovr = 1'b0;

    // Table sequence continuing from last grant = 2.
    vecs[0]  = '{4'b1111, 3, 0};
    vecs[1]  = '{4'b1111, 0, 0};
    vecs[2]  = '{4'b0011, 1, 0};
    vecs[3]  = '{4'b0011, 0, 0};
    vecs[4]  = '{4'b1000, 3, 0};
    vecs[5]  = '{4'b1001, 0, 10};  // back-pressure
    vecs[6]  = '{4'b0110, 1, 0};
    vecs[7]  = '{4'b0100, 2, 0};
    vecs[8]  = '{4'b0011, 0, 0};   // skip/wrap from last grant 2
    vecs[9]  = '{4'b0011, 1, 0};   // 0 re-requesting waits behind 1
    vecs[10] = '{4'b1010, 3, 0};
    vecs[11] = '{4'b1110, 1, 0};
    for (int i = 0; i < 12; i++) begin
      randomize_data();
      run_txn(vecs[i].mask, vecs[i].exp_id, vecs[i].hold, $sformatf("vec%0d", i));
    end

    // Round-robin with all requesters continuously valid.
    do_reset();
    randomize_data();
    req_valid = 4'b1111;
    grants = 0; last_cyc = 0;
    for (cyc = 0; cyc < 60 && grants < 8; cyc++) begin
      #1;
      if (rsp_valid) begin
        if (id_q.size() == 0) chk("rr unexpected rsp", 64'(rsp_valid), 0);
        else chk("rr rsp_id", 64'(rsp_id), 64'(id_q.pop_front()));
      end
      if (req_ready != '0) begin
        chk("rr grant", 64'(req_ready), 64'(1) << (grants % N));
        if (grants > 0) chk("rr spacing", 64'(cyc - last_cyc), 3);
        id_q.push_back(IW'(grants % N));
        last_cyc = cyc;
        grants++;
      end
      @(negedge clk);
    end
    chk("rr grant count", 64'(grants), 8);

    // Reset during EXEC drops the operation; requester 0 wins afterwards.
    do_reset();
    randomize_data();
    req_valid = 4'b1000;
    @(posedge clk);
    #1 req_valid = 4'b1001;
    @(negedge clk);
    chk("rst pre busy", 64'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    req_valid = '0;
    run_txn(4'b1001, 0, 0, "post rst");

    // Counter wrap via backdoor preload.
    force dut.ops_done_q = 16'hFFFF;
    #1 release dut.ops_done_q;
    ops_exp = 16'hFFFF;
    randomize_data();
    run_txn(4'b0010, 1, 0, "wrap");
    chk("wrap zero", 64'(ops_done), 0);

    // Random phase against the priority-list model.
    do_reset();
    for (int i = 0; i < 150; i++) begin
      randomize_data();
      m = N'($urandom_range(0, 15));
      if (m == '0) begin
        req_valid = '0;
        #1;
        chk("rand none ready", 64'(req_ready), 0);
        @(negedge clk);
      end else begin
        g = model_grant(m);
        run_txn(m, g, $urandom_range(0, 3), $sformatf("rand%0d", i));
        model_commit(g);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
